// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared encodings for the RV32I memory-access stage and
//                MEM/WB register. Holds the funct3 load/store widths, the
//                ResultSrc selections, the ExcW cause codes and the FSM state
//                encodings. Also holds the legality and alignment helpers
//                used to decide whether a request may be issued.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    // funct3 width/sign codes. Stores use only the first three.
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // ResultSrc selections seen by the write-back mux
    localparam logic [1:0] c_rs_alu  = 2'b00;
    localparam logic [1:0] c_rs_load = 2'b01;
    localparam logic [1:0] c_rs_pc4  = 2'b10;

    // ExcW cause codes
    localparam logic [1:0] c_exc_none     = 2'b00;
    localparam logic [1:0] c_exc_misalign = 2'b01;
    localparam logic [1:0] c_exc_timeout  = 2'b10;
    localparam logic [1:0] c_exc_illegal  = 2'b11;

    // Memory handshake FSM states
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_wait = 1'b1;

    // A load accepts B/H/W/BU/HU; a store accepts B/H/W only.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic v_ok;
        v_ok = 1'b0;
        case (f3)
            c_f3_b, c_f3_h, c_f3_w: v_ok = 1'b1;
            c_f3_bu, c_f3_hu:       v_ok = ~is_store;
            default:                v_ok = 1'b0;
        endcase
        return v_ok;
    endfunction

    // Halfwords need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic v_mis;
        v_mis = 1'b0;
        case (f3)
            c_f3_h, c_f3_hu: v_mis = addr_lo[0];
            c_f3_w:          v_mis = (addr_lo != 2'b00);
            default:         v_mis = 1'b0;
        endcase
        return v_mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_load_align
//  Description : Combinational load-data aligner. Picks the addressed byte or
//                halfword lane out of the returned memory word and sign- or
//                zero-extends it according to funct3. LW (and any other code)
//                passes the whole word through.
//  Ports       : i_funct3  [3]  load width/sign
//                i_addr_lo [2]  byte offset within the word
//                i_rdata   [32] word returned by data memory
//                o_data    [32] aligned, extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane is addr[1:0]; halfword lane is addr[1] (addr[0] is known 0).
    assign w_byte = i_rdata[8*i_addr_lo +: 8];
    assign w_half = i_rdata[16*i_addr_lo[1] +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            c_f3_b:  o_data = {{24{w_byte[7]}}, w_byte};
            c_f3_h:  o_data = {{16{w_half[15]}}, w_half};
            c_f3_bu: o_data = {24'd0, w_byte};
            c_f3_hu: o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : RV32I memory-access stage plus MEM/WB pipeline register.
//                Issues req/ack data-memory accesses with byte enables,
//                aligns load data, stalls the upstream pipeline while memory
//                is busy, and reports misaligned / illegal / timed-out
//                accesses through ExcW.
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                RegWriteM..PCPlus4M      instruction fields from the M stage
//                dmem_*                   variable-latency data-memory port
//                StallM                   hold F/D/E/M while memory is busy
//                RegWriteW..RdW, ExcW     registered write-back inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        rst,
    // M-stage instruction
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    // data memory
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    // hazard unit
    output logic        StallM,
    // write-back inputs
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic [1:0]  ExcW
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    // ------------------------------------------------------------------
    // Decode of the M-stage instruction
    // ------------------------------------------------------------------
    logic        w_is_mem;
    logic        w_f3_ok;
    logic        w_misal;
    logic        w_mem_go;
    logic [1:0]  w_exc_cause;

    assign w_is_mem = MemWriteM | (ResultSrcM == c_rs_load);
    assign w_f3_ok  = f3_legal(MemWriteM, Funct3M);
    assign w_misal  = is_misaligned(Funct3M, ALUResultM[1:0]);
    assign w_mem_go = w_is_mem & w_f3_ok & ~w_misal;

    // Illegal funct3 is checked first: alignment is meaningless without a
    // valid width.
    always_comb begin
        w_exc_cause = c_exc_none;
        if (w_is_mem) begin
            if (!w_f3_ok)
                w_exc_cause = c_exc_illegal;
            else if (w_misal)
                w_exc_cause = c_exc_misalign;
        end
    end

    // ------------------------------------------------------------------
    // Store lanes and memory address
    // ------------------------------------------------------------------
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (MemWriteM) begin
            case (Funct3M[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteDataM;
                end
            endcase
        end
    end

    assign dmem_we    = MemWriteM;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_req;
    logic        w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter holds the number of cycles the request has already been
    // outstanding; reaching TIMEOUT without an ack aborts. Ack on that same
    // cycle still wins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req       = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_mem_go) begin
                    w_req = 1'b1;
                    if (!dmem_ack) begin
                        w_state_nxt = c_st_wait;
                        w_cnt_nxt   = 16'd1;
                    end
                end
            end
            c_st_wait: begin
                if (dmem_ack) begin
                    w_req       = 1'b1;
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 16'd0;
                end else begin
                    w_req     = 1'b1;
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 16'd0;
            end
        endcase
    end

    // Reset gates the request off immediately, even mid-transaction.
    assign dmem_req = w_req & ~rst;
    assign StallM   = dmem_req & ~dmem_ack & ~w_abort;

    logic w_done;
    assign w_done = dmem_req & dmem_ack;

    // ------------------------------------------------------------------
    // Load alignment
    // ------------------------------------------------------------------
    logic [31:0] w_load_val;

    mem_wb_stage_load_align u_load_align (
        .i_funct3  (Funct3M),
        .i_addr_lo (ALUResultM[1:0]),
        .i_rdata   (dmem_rdata),
        .o_data    (w_load_val)
    );

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic [1:0] w_exc_w;
    assign w_exc_w = w_abort ? c_exc_timeout : w_exc_cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= c_rs_alu;
            ReadDataW  <= 32'd0;
            ALUResultW <= 32'd0;
            PCPlus4W   <= 32'd0;
            RdW        <= 5'd0;
            ExcW       <= c_exc_none;
        end else if (StallM) begin
            // Bubble: the instruction stays in M until memory answers.
            RegWriteW  <= 1'b0;
            ResultSrcW <= c_rs_alu;
            ReadDataW  <= 32'd0;
            ALUResultW <= 32'd0;
            PCPlus4W   <= 32'd0;
            RdW        <= 5'd0;
            ExcW       <= c_exc_none;
        end else begin
            RegWriteW  <= RegWriteM & (w_exc_w == c_exc_none);
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= (w_done && !MemWriteM) ? w_load_val : 32'd0;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ExcW       <= w_exc_w;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Directed self-checking bench for mem_wb_stage (TIMEOUT=4).
//                Inputs change 1 ns after the rising edge; combinational
//                outputs are sampled in the same cycle, registered outputs
//                1 ns after the following edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUResultW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [1:0]  ExcW;

    int checks;
    int errors;

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCPlus4M   (PCPlus4M),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .ExcW       (ExcW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic rw, input logic [1:0] rs, input logic mw,
                          input logic [2:0] f3, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] pc4);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        Funct3M    = f3;
        ALUResultM = alu;
        WriteDataM = wd;
        RdM        = rd;
        PCPlus4M   = pc4;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        // A legal LW sits in M during reset: no request may escape.
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd9, 32'h40);
        tick();
        tick();
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", StallM, 1'b0);
        chk("rst_regwrite", RegWriteW, 1'b0);
        chk("rst_alu", ALUResultW, 32'h0);
        chk("rst_rd", RdW, 5'd0);

        // ADD, non-memory: one cycle to W, no request
        rst = 1'b0;
        set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 32'h44);
        #1;
        chk("add_req", dmem_req, 1'b0);
        chk("add_stall", StallM, 1'b0);
        tick();
        chk("add_regwrite", RegWriteW, 1'b1);
        chk("add_alu", ALUResultW, 32'h0000_1234);
        chk("add_rd", RdW, 5'd5);
        chk("add_pc4", PCPlus4W, 32'h44);
        chk("add_exc", ExcW, 2'b00);

        // LB 0x103, zero-wait ack
        set_op(1'b1, 2'b01, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h48);
        dmem_rdata = 32'h80FF_0000;
        dmem_ack   = 1'b1;
        #1;
        chk("lb_req", dmem_req, 1'b1);
        chk("lb_stall", StallM, 1'b0);
        chk("lb_we", dmem_we, 1'b0);
        chk("lb_be", dmem_be, 4'b1111);
        chk("lb_addr", dmem_addr, 32'h0000_0100);
        tick();
        chk("lb_data", ReadDataW, 32'hFFFF_FF80);
        chk("lb_rs", ResultSrcW, 2'b01);
        chk("lb_regwrite", RegWriteW, 1'b1);

        // LBU same address/data
        Funct3M = 3'b100;
        #1;
        chk("lbu_stall", StallM, 1'b0);
        tick();
        chk("lbu_data", ReadDataW, 32'h0000_0080);

        // LH 0x100
        set_op(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0100, 32'h0, 5'd8, 32'h4C);
        dmem_rdata = 32'h1234_8765;
        tick();
        chk("lh_data", ReadDataW, 32'hFFFF_8765);
        // LHU 0x102
        set_op(1'b1, 2'b01, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd8, 32'h50);
        dmem_rdata = 32'h8765_1234;
        tick();
        chk("lhu_data", ReadDataW, 32'h0000_8765);
        // LW 0x104
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 5'd10, 32'h54);
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("lw_data", ReadDataW, 32'hDEAD_BEEF);
        chk("lw_rd", RdW, 5'd10);

        // SH 0x102, ack after 3 stall cycles
        dmem_ack = 1'b0;
        set_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 32'h58);
        #1;
        chk("sh_req", dmem_req, 1'b1);
        chk("sh_we", dmem_we, 1'b1);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        for (int i = 0; i < 3; i++) begin
            chk("sh_stall", StallM, 1'b1);
            tick();
            chk("sh_bubble_rw", RegWriteW, 1'b0);
            chk("sh_bubble_exc", ExcW, 2'b00);
            chk("sh_req_hold", dmem_req, 1'b1);
        end
        dmem_ack = 1'b1;
        #1;
        chk("sh_ack_stall", StallM, 1'b0);
        tick();
        dmem_ack = 1'b0;
        chk("sh_w_rw", RegWriteW, 1'b0);
        chk("sh_w_exc", ExcW, 2'b00);
        chk("sh_w_alu", ALUResultW, 32'h0000_0102);
        chk("sh_w_pc4", PCPlus4W, 32'h58);
        chk("sh_w_data", ReadDataW, 32'h0);

        // SB 0x201 with zero-wait ack
        set_op(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_565A, 5'd0, 32'h5C);
        dmem_ack = 1'b1;
        #1;
        chk("sb_be", dmem_be, 4'b0010);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        chk("sb_addr", dmem_addr, 32'h0000_0200);
        // SW 0x204
        set_op(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0204, 32'h1122_3344, 5'd0, 32'h60);
        #1;
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'h1122_3344);
        tick();

        // Spurious ack during a non-memory op (PC+4 select)
        set_op(1'b1, 2'b10, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 5'd1, 32'h64);
        #1;
        chk("spur_req", dmem_req, 1'b0);
        chk("spur_stall", StallM, 1'b0);
        tick();
        dmem_ack = 1'b0;
        chk("spur_rw", RegWriteW, 1'b1);
        chk("spur_rs", ResultSrcW, 2'b10);
        chk("spur_data", ReadDataW, 32'h0);

        // Misaligned LW
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 32'h68);
        #1;
        chk("mis_lw_req", dmem_req, 1'b0);
        tick();
        chk("mis_lw_exc", ExcW, 2'b01);
        chk("mis_lw_rw", RegWriteW, 1'b0);
        chk("mis_lw_data", ReadDataW, 32'h0);
        // Misaligned SH
        set_op(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0103, 32'h0, 5'd0, 32'h6C);
        #1;
        chk("mis_sh_req", dmem_req, 1'b0);
        tick();
        chk("mis_sh_exc", ExcW, 2'b01);
        // Illegal load funct3 011
        set_op(1'b1, 2'b01, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd4, 32'h70);
        #1;
        chk("ill_ld_req", dmem_req, 1'b0);
        tick();
        chk("ill_ld_exc", ExcW, 2'b11);
        chk("ill_ld_rw", RegWriteW, 1'b0);
        // Illegal store funct3 100
        set_op(1'b0, 2'b00, 1'b1, 3'b100, 32'h0000_0100, 32'h0, 5'd0, 32'h74);
        #1;
        chk("ill_st_req", dmem_req, 1'b0);
        tick();
        chk("ill_st_exc", ExcW, 2'b11);

        // Timeout: LW with no ack, TIMEOUT=4
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd6, 32'h78);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", StallM, 1'b1);
            tick();
        end
        chk("to_abort_stall", StallM, 1'b0);
        chk("to_abort_req", dmem_req, 1'b0);
        tick();
        chk("to_exc", ExcW, 2'b10);
        chk("to_rw", RegWriteW, 1'b0);
        chk("to_data", ReadDataW, 32'h0);
        // FSM back in IDLE: a new zero-wait load completes at once
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 5'd11, 32'h7C);
        dmem_rdata = 32'hCAFE_F00D;
        dmem_ack   = 1'b1;
        #1;
        chk("post_to_stall", StallM, 1'b0);
        tick();
        dmem_ack = 1'b0;
        chk("post_to_data", ReadDataW, 32'hCAFE_F00D);
        chk("post_to_exc", ExcW, 2'b00);

        // Reset while waiting
        set_op(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd12, 32'h80);
        tick();
        chk("rw_wait_stall", StallM, 1'b1);
        rst = 1'b1;
        #1;
        chk("rw_req_gated", dmem_req, 1'b0);
        tick();
        chk("rw_rw", RegWriteW, 1'b0);
        chk("rw_alu", ALUResultW, 32'h0);
        chk("rw_pc4", PCPlus4W, 32'h0);
        chk("rw_exc", ExcW, 2'b00);
        // Late ack after reset must be ignored
        rst = 1'b0;
        set_op(1'b1, 2'b00, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 5'd13, 32'h84);
        dmem_ack = 1'b1;
        #1;
        chk("late_ack_req", dmem_req, 1'b0);
        chk("late_ack_stall", StallM, 1'b0);
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_rw", RegWriteW, 1'b1);
        chk("late_ack_alu", ALUResultW, 32'h0000_0055);
        chk("late_ack_data", ReadDataW, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the RV32I pipeline; sits directly upstream of the write-back stage and produces its ResultSrcW/ReadDataW/ALUResultW/PCPlus4W inputs.
- Drives a variable-latency req/ack data-memory port with byte lanes, aligns and extends load data, stalls the pipeline while memory is busy, and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 255, max cycles dmem_req waits for dmem_ack before abort (1..65535).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- RegWriteM  in  1  register-write enable of the instruction in M
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4
- MemWriteM  in  1  store
- Funct3M  in  3  load/store width and sign
- ALUResultM  in  32  effective address or ALU result
- WriteDataM  in  32  store data (rs2)
- RdM  in  5  destination register
- PCPlus4M  in  32  PC+4
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {ALUResultM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word, valid with dmem_ack
- dmem_ack  in  1  completion; one cycle per request
- StallM  out  1  to hazard unit: hold F/D/E/M
- RegWriteW, ResultSrcW[2], ReadDataW[32], ALUResultW[32], PCPlus4W[32], RdW[5]  out  registered WB inputs
- ExcW  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3

Behaviour:
- Memory op = MemWriteM | (ResultSrcM==01). Non-memory ops pass to W in 1 cycle, no request.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010. Others -> no request, ExcW=11.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0 -> no request, ExcW=01. Any exception forces RegWriteW=0, ReadDataW=0.
- dmem_be: SB 0001<<addr[1:0]; SH 0011<<{addr[1],0}; SW 1111; loads 1111. dmem_wdata: SB {4{b}}, SH {2{h}}, SW word.
- FSM IDLE/WAIT, 16-bit wait counter. IDLE: legal memory op -> dmem_req=1 combinationally; ack same cycle -> complete, stay IDLE; else -> WAIT, counter=1. WAIT: dmem_req held, address/data stable (upstream frozen by StallM); ack -> complete, IDLE; counter==TIMEOUT without ack -> abort: req drops, ExcW=10, RegWriteW=0, IDLE; else counter++.
- StallM = dmem_req & ~dmem_ack & ~abort. Combinational.
- Every cycle StallM=0 the W register loads M fields; ReadDataW on loads = lane byte/half from dmem_rdata[8*addr[1:0]+:] sign- (LB/LH) or zero-extended (LBU/LHU), LW whole word. Stores: ReadDataW=0.
- Every cycle StallM=1 the W register loads a bubble: RegWriteW=0, ExcW=00, ResultSrcW=00, other fields don't-care; the previous W instruction retires exactly once.
- dmem_ack while no request outstanding: ignored.
- Reset (any state, incl. WAIT): FSM IDLE, counter 0, all W outputs 0; dmem_req gated to 0 in any cycle rst=1; memory must tolerate an abandoned request.
- Latency: non-memory op 1 cycle M->W; memory op 1 + wait cycles.

Decomposition:
- Shared package: funct3 load/store codes, ResultSrc encodings, ExcW cause codes, FSM state encodings.
- One sub-module: load_align (combinational: funct3, addr[1:0], rdata -> extended 32-bit value); store lane/BE logic stays inline.

Test Plan:
- ADD result 0x1234, Rd=5, ResultSrcM=00 -> next cycle RegWriteW=1, ALUResultW=0x1234, RdW=5, no dmem_req.
- LB addr 0x103, rdata 0x80FF_0000 with 0-wait ack -> ReadDataW=0xFFFF_FF80, StallM never high; LBU same -> 0x0000_0080.
- SH addr 0x102 data 0xABCD, ack after 3 cycles -> dmem_be=1100, wdata=0xABCD_ABCD, StallM high exactly 3 cycles, 3 bubbles then store in W with RegWriteW=0 and ExcW=00.
- LW addr 0x101 -> no dmem_req, ExcW=01, RegWriteW=0; Funct3M=011 load -> ExcW=11.
- TIMEOUT=4, no ack -> StallM high 4 cycles, then ExcW=10, RegWriteW=0, FSM back to IDLE.
- rst asserted during WAIT -> dmem_req low same cycle, all W outputs 0 next edge; late ack ignored.
